// File: rtl/sha1_pad_sched.sv
// FIPS 180 padder/sequencer in front of sha_1_core: passes message words straight through,
// then appends marker, zero fill and the 64-bit length in 16-word blocks.
module sha1_pad_sched #(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] msg_din,
  input  logic        msg_vld,
  input  logic        msg_last,
  input  logic [1:0]  msg_nbytes,
  output logic        msg_rdy,
  output logic [31:0] core_din,
  output logic        core_din_vld,
  output logic        core_use_pre_cv,
  output logic        core_sha_1_end,
  input  logic        core_busy,
  input  logic        core_dout_vld,
  output logic        done,
  output logic        active
);

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_MARK, S_ZERO, S_LENHI, S_LENLO, S_BWAIT, S_FIN
  } state_t;

  state_t           r_state, r_ret;
  logic [3:0]       r_wcnt;
  logic             r_blk_first, r_end, r_end_nxt, r_seen_busy, r_done;
  logic [LEN_W-1:0] r_bitlen;

  logic        w_in_data, w_rdy, w_acc, w_pad, w_emit, w_mark_now, w_final_now;
  logic [5:0]  w_bits;
  logic [63:0] w_len64;
  logic [31:0] w_din;
  state_t      w_nxt;

  assign w_in_data   = (r_state == S_IDLE) || (r_state == S_DATA);
  assign w_rdy       = !rst && w_in_data && !core_busy;
  assign w_acc       = w_rdy && msg_vld;
  assign w_pad       = (r_state == S_MARK) || (r_state == S_ZERO) ||
                       (r_state == S_LENHI) || (r_state == S_LENLO);
  assign w_emit      = w_acc || (w_pad && !core_busy && !rst);
  // The marker lands either inside a short last word or as its own MARK word.
  assign w_mark_now  = (w_acc && msg_last && (msg_nbytes != 2'd0)) ||
                       ((r_state == S_MARK) && w_emit);
  assign w_final_now = r_end || (w_mark_now && (r_wcnt <= 4'd13));
  assign w_bits      = (msg_nbytes == 2'd0 || !msg_last) ? 6'd32 : {1'b0, msg_nbytes, 3'b000};
  assign w_len64     = 64'(r_bitlen);

  always_comb begin
    w_din = 32'h0;
    case (r_state)
      S_IDLE, S_DATA: begin
        w_din = msg_din;
        if (msg_last) begin
          case (msg_nbytes)
            2'd1:    w_din = {msg_din[31:24], 8'h80, 16'h0};
            2'd2:    w_din = {msg_din[31:16], 8'h80, 8'h0};
            2'd3:    w_din = {msg_din[31:8], 8'h80};
            default: w_din = msg_din;
          endcase
        end
      end
      S_MARK:  w_din = 32'h8000_0000;
      S_LENHI: w_din = w_len64[63:32];
      S_LENLO: w_din = w_len64[31:0];
      default: w_din = 32'h0;
    endcase
  end

  // State following the word emitted this cycle, ignoring the block boundary.
  always_comb begin
    w_nxt = S_ZERO;
    case (r_state)
      S_IDLE, S_DATA: begin
        if (!msg_last)               w_nxt = S_DATA;
        else if (msg_nbytes == 2'd0) w_nxt = S_MARK;
        else                         w_nxt = (w_final_now && r_wcnt == 4'd13) ? S_LENHI : S_ZERO;
      end
      S_MARK:  w_nxt = (w_final_now && r_wcnt == 4'd13) ? S_LENHI : S_ZERO;
      S_ZERO:  w_nxt = (r_end && r_wcnt == 4'd13) ? S_LENHI : S_ZERO;
      S_LENHI: w_nxt = S_LENLO;
      S_LENLO: w_nxt = S_FIN;
      default: w_nxt = S_ZERO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ret       <= S_IDLE;
      r_wcnt      <= 4'd0;
      r_blk_first <= 1'b0;
      r_end       <= 1'b0;
      r_end_nxt   <= 1'b0;
      r_seen_busy <= 1'b0;
      r_done      <= 1'b0;
      r_bitlen    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_emit) begin
        r_wcnt <= r_wcnt + 4'd1;
        if (w_acc) r_bitlen <= r_bitlen + LEN_W'(w_bits);
        if (r_state == S_IDLE) r_blk_first <= 1'b1;
        if (w_mark_now) begin
          if (r_wcnt <= 4'd13) r_end     <= 1'b1;
          else                 r_end_nxt <= 1'b1;
        end
        if (r_wcnt == 4'd15) begin
          // Marker in word 15 makes the following block the final one.
          r_blk_first <= 1'b0;
          r_end       <= r_end_nxt | w_mark_now;
          r_end_nxt   <= 1'b0;
          if (w_nxt == S_FIN) r_state <= S_FIN;
          else begin
            r_state <= S_BWAIT;
            r_ret   <= w_nxt;
          end
        end else begin
          r_state <= w_nxt;
        end
      end else begin
        case (r_state)
          S_BWAIT: begin
            if (core_busy) r_seen_busy <= 1'b1;
            else if (r_seen_busy) begin
              r_seen_busy <= 1'b0;
              r_state     <= r_ret;
            end
          end
          S_FIN: begin
            if (core_dout_vld) begin
              r_done      <= 1'b1;
              r_state     <= S_IDLE;
              r_wcnt      <= 4'd0;
              r_bitlen    <= '0;
              r_end       <= 1'b0;
              r_end_nxt   <= 1'b0;
              r_blk_first <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign msg_rdy         = w_rdy;
  assign core_din_vld    = w_emit;
  assign core_din        = w_emit ? w_din : 32'h0;
  assign core_use_pre_cv = !rst && (r_state != S_IDLE) && !r_blk_first;
  assign core_sha_1_end  = !rst && (r_end || (w_mark_now && (r_wcnt <= 4'd13)));
  assign done            = r_done;
  assign active          = !rst && (r_state != S_IDLE);

endmodule
